// File: rtl/pdm_sd_modulator.sv
// rtl/pdm_sd_modulator.sv - second-order delta-sigma PCM to PDM modulator
//
// Purpose:
//   Turns a stream of signed DATA_W-bit PCM samples into a 1-bit PDM
//   bitstream, emitting OSR bits per sample. Two sample registers are used:
//   cur (being modulated) and nxt (one-entry buffer). If no new sample is
//   waiting when a slot ends, cur is repeated and the underrun bit is raised
//   in out_error, so the stream never stalls.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clken      clock enable; 0 freezes every register
//   in_data    signed PCM sample
//   in_valid   sample valid
//   in_ready   sink ready (nxt buffer empty)
//   in_error   2-bit error tag travelling with the sample
//   out_data   PDM bit
//   out_valid  bitstream valid (sticky after the first sample)
//   out_ready  downstream accepts the current bit
//   out_error  tag of the sample being modulated, bit 0 set on underrun

module pdm_sd_modulator #(
  parameter int DATA_W = 16,
  parameter int OSR    = 64,
  parameter int INT_W  = DATA_W + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_error,
  output logic              out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_error
);

  // Sums are formed two bits wider than the integrators so that the
  // worst-case i + x - fb never wraps before the clamp.
  localparam int SUM_W = INT_W + 2;
  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic signed [SUM_W-1:0] FS_EXT =
    {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI =
    {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO =
    {3'b111, {(INT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  // Sample storage
  logic [DATA_W-1:0]        cur_data;
  logic [1:0]               cur_err;
  logic                     cur_full;
  logic [DATA_W-1:0]        nxt_data;
  logic [1:0]               nxt_err;
  logic                     nxt_full;

  // Modulator state
  logic signed [INT_W-1:0]  i1;
  logic signed [INT_W-1:0]  i2;
  logic [CNT_W-1:0]         cnt;
  logic                     bit_q;
  logic [1:0]               err_q;

  // Next-state terms
  logic signed [SUM_W-1:0]  fb;
  logic signed [SUM_W-1:0]  cur_ext;
  logic signed [SUM_W-1:0]  i1_ext;
  logic signed [SUM_W-1:0]  i2_ext;
  logic signed [SUM_W-1:0]  i1_sum;
  logic signed [SUM_W-1:0]  i2_sum;
  logic signed [INT_W-1:0]  i1_next;
  logic signed [INT_W-1:0]  i2_next;
  logic signed [SUM_W-1:0]  i1_next_ext;
  logic                     bit_next;

  logic                     accept;
  logic                     advance;
  logic                     slot_end;

  function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    logic signed [INT_W-1:0] r;
    if (v > SAT_HI) begin
      r = {1'b0, {(INT_W-1){1'b1}}};
    end else if (v < SAT_LO) begin
      r = {1'b1, {(INT_W-1){1'b0}}};
    end else begin
      r = v[INT_W-1:0];
    end
    return r;
  endfunction

  assign in_ready  = !nxt_full;
  assign out_valid = cur_full;
  assign out_data  = bit_q;
  assign out_error = err_q;

  assign accept   = clken & in_valid & !nxt_full;
  assign advance  = clken & cur_full & out_ready;
  assign slot_end = advance & (cnt == CNT_LAST);

  // Loop filter: two cascaded saturating integrators, both fed back from
  // the previously emitted bit; the second sees the first's new value.
  always_comb begin
    fb          = bit_q ? FS_EXT : -FS_EXT;
    cur_ext     = {{(SUM_W-DATA_W){cur_data[DATA_W-1]}}, cur_data};
    i1_ext      = {{(SUM_W-INT_W){i1[INT_W-1]}}, i1};
    i2_ext      = {{(SUM_W-INT_W){i2[INT_W-1]}}, i2};
    i1_sum      = i1_ext + cur_ext - fb;
    i1_next     = sat(i1_sum);
    i1_next_ext = {{(SUM_W-INT_W){i1_next[INT_W-1]}}, i1_next};
    i2_sum      = i2_ext + i1_next_ext - fb;
    i2_next     = sat(i2_sum);
    bit_next    = !i2_next[INT_W-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_data <= '0;
      cur_err  <= '0;
      cur_full <= 1'b0;
      nxt_data <= '0;
      nxt_err  <= '0;
      nxt_full <= 1'b0;
      i1       <= '0;
      i2       <= '0;
      cnt      <= '0;
      bit_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      if (advance) begin
        i1    <= i1_next;
        i2    <= i2_next;
        bit_q <= bit_next;
        cnt   <= slot_end ? '0 : cnt + CNT_W'(1);
      end

      // A slot end implies cur is full; when nxt is full, in_ready is low,
      // so an accept can only coincide with a slot end through the bypass.
      if (slot_end) begin
        if (nxt_full) begin
          cur_data <= nxt_data;
          cur_err  <= nxt_err;
          nxt_full <= 1'b0;
          err_q    <= nxt_err;
        end else if (accept) begin
          cur_data <= in_data;
          cur_err  <= in_error;
          err_q    <= in_error;
        end else begin
          err_q    <= cur_err | 2'b01;
        end
      end else if (accept) begin
        if (!cur_full) begin
          cur_data <= in_data;
          cur_err  <= in_error;
          cur_full <= 1'b1;
          err_q    <= in_error;
        end else begin
          nxt_data <= in_data;
          nxt_err  <= in_error;
          nxt_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_sd_modulator.sv
// tb/tb_pdm_sd_modulator.sv - self-checking bench for pdm_sd_modulator

module tb_pdm_sd_modulator;

  localparam int DATA_W = 16;
  localparam int OSR    = 64;
  localparam int INT_W  = DATA_W + 4;
  localparam int FS     = 1 << (DATA_W - 1);
  localparam int SAT_HI = (1 << (INT_W - 1)) - 1;
  localparam int SAT_LO = -(1 << (INT_W - 1));

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clken;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_error;
  logic              out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_error;

  pdm_sd_modulator #(.DATA_W(DATA_W), .OSR(OSR), .INT_W(INT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_error  (in_error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted samples (head = sample being
  // modulated), integer integrators, and a position within the slot.
  typedef struct {
    int         data;
    logic [1:0] err;
  } samp_t;

  samp_t      mq[$];
  bit         mv;
  bit         mbit;
  int         mi1;
  int         mi2;
  int         mpos;
  logic [1:0] merr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int lo;
    int hi;
  } dens_t;

  dens_t dens_tab[5];

  function automatic int clamp(input int v);
    if (v > SAT_HI) return SAT_HI;
    if (v < SAT_LO) return SAT_LO;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    mv   = 1'b0;
    mbit = 1'b0;
    mi1  = 0;
    mi2  = 0;
    mpos = 0;
    merr = 2'b00;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // One clock: predict from the inputs presented now, clock, then compare.
  task automatic step();
    bit    acc;
    bit    adv;
    int    fb;
    samp_t s;
    acc    = reset_n && clken && in_valid && (mq.size() < 2);
    adv    = reset_n && clken && mv && out_ready;
    s.data = int'($signed(in_data));
    s.err  = in_error;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (adv) begin
        fb   = mbit ? FS : -FS;
        mi1  = clamp(mi1 + mq[0].data - fb);
        mi2  = clamp(mi2 + mi1 - fb);
        mbit = (mi2 >= 0);
        mpos++;
      end
      if (acc) begin
        if (mq.size() == 0) begin
          mv   = 1'b1;
          merr = s.err;
        end
        mq.push_back(s);
      end
      if (adv && mpos == OSR) begin
        mpos = 0;
        if (mq.size() > 1) begin
          void'(mq.pop_front());
          merr = mq[0].err;
        end else begin
          merr = mq[0].err | 2'b01;
        end
      end
    end
    #1;
    check("out_data", int'(out_data), int'(mbit));
    check("out_valid", int'(out_valid), int'(mv));
    check("out_error", int'(out_error), int'(merr));
    check("in_ready", int'(in_ready), int'(mq.size() < 2));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int ones;
    int nacc;
    int v;
    logic saved_bit;
    logic [1:0] saved_err;

    dens_tab[0] = '{x: 0,      lo: 31, hi: 33};
    dens_tab[1] = '{x: 16384,  lo: 46, hi: 50};
    dens_tab[2] = '{x: -16384, lo: 14, hi: 18};
    dens_tab[3] = '{x: 8192,   lo: 38, hi: 42};
    dens_tab[4] = '{x: -8192,  lo: 22, hi: 26};

    reset_n   = 1'b0;
    clken     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_error  = 2'b00;
    out_ready = 1'b1;
    model_reset();
    step();
    step();
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_error", int'(out_error), 0);
    check("reset_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;

    // Handshake: in_valid held high from reset
    in_valid = 1'b1;
    in_data  = '0;
    step();
    check("hs_valid_latency", int'(out_valid), 1);
    check("hs_first_to_cur", int'(in_ready), 1);
    step();
    check("hs_nxt_full", int'(in_ready), 0);
    nacc = 0;
    for (int k = 0; k < 2 * OSR; k++) begin
      if (in_ready) nacc++;
      step();
    end
    check("hs_accepts_per_two_slots", nacc, 2);

    // Ones density per slot for constant inputs
    for (int t = 0; t < 5; t++) begin
      do_reset();
      in_valid = 1'b1;
      in_error = 2'b00;
      in_data  = DATA_W'(dens_tab[t].x);
      step();
      repeat (2 * OSR) step();
      for (int sl = 0; sl < 2; sl++) begin
        ones = 0;
        for (int k = 0; k < OSR; k++) begin
          step();
          ones += int'(out_data);
        end
        check_rng($sformatf("density_x%0d_slot%0d", dens_tab[t].x, sl), ones,
                  dens_tab[t].lo, dens_tab[t].hi);
      end
      check("density_err", int'(out_error), 0);
    end

    // Backpressure mid-slot
    repeat (20) step();
    out_ready = 1'b0;
    saved_bit = out_data;
    repeat (100) step();
    check("bp_bit_frozen", int'(out_data), int'(saved_bit));
    check("bp_in_ready_low", int'(in_ready), 0);
    out_ready = 1'b1;
    repeat (200) step();

    // Underrun: one sample then nothing
    do_reset();
    in_valid = 1'b1;
    in_data  = DATA_W'(8192);
    in_error = 2'b10;
    step();
    in_valid = 1'b0;
    check("ur_first_err", int'(out_error), 2);
    repeat (OSR) step();
    check("ur_err_flag", int'(out_error), 3);
    check("ur_valid_held", int'(out_valid), 1);
    ones = 0;
    for (int k = 0; k < OSR; k++) begin
      step();
      ones += int'(out_data);
    end
    check("ur_err_repeat", int'(out_error), 3);
    check_rng("ur_density", ones, 38, 42);
    in_valid = 1'b1;
    in_error = 2'b00;
    step();
    in_valid = 1'b0;
    check("ur_new_in_nxt", int'(in_ready), 0);
    repeat (OSR - 1) step();
    check("ur_err_cleared", int'(out_error), 0);
    check("ur_ready_again", int'(in_ready), 1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      v         = int'($urandom_range(0, 49152)) - 24576;
      in_data   = DATA_W'(v);
      in_error  = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 8);
      clken     = ($urandom_range(0, 9) < 9);
      step();
    end

    // Clock enable low mid-slot
    clken     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (13) step();
    clken     = 1'b0;
    saved_bit = out_data;
    saved_err = out_error;
    repeat (10) step();
    check("clken_bit_hold", int'(out_data), int'(saved_bit));
    check("clken_err_hold", int'(out_error), int'(saved_err));
    clken = 1'b1;
    repeat (17) step();

    // Asynchronous reset mid-slot, then restart
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_out_valid", int'(out_valid), 0);
    check("areset_out_data", int'(out_data), 0);
    check("areset_in_ready", int'(in_ready), 1);
    check("areset_out_error", int'(out_error), 0);
    model_reset();
    step();
    step();
    reset_n  = 1'b1;
    in_data  = DATA_W'(8192);
    in_error = 2'b00;
    repeat (200) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
